// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            rx_data_i;
   logic                  rx_valid_i;
   logic                  rx_ready_o;
   logic                  wr_en_o;
   logic [DATA_WIDTH-1:0] wr_addr_o;
   logic [DATA_WIDTH-1:0] wr_data_o;
   logic                  done_o;
   logic                  error_o;
   logic                  cpu_reset_o;

   modport slave (
      input  rx_data_i, rx_valid_i,
      output rx_ready_o, wr_en_o, wr_addr_o, wr_data_o, done_o, error_o, cpu_reset_o
   );

   modport master (
      output rx_data_i, rx_valid_i,
      input  rx_ready_o, wr_en_o, wr_addr_o, wr_data_o, done_o, error_o, cpu_reset_o
   );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed byte stream (count, LE words, XOR checksum) into instruction memory.
// Writes issue one cycle after each word's last byte; the CPU stays in reset until a good checksum.
module prog_loader #(
   parameter int                    MEMORY_DEPTH = 64,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
   input  logic          clk_i,
   input  logic          reset_i,
   prog_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state;
   state_t      nxt_state;
   logic [15:0] count;
   logic [15:0] nxt_count;
   logic [15:0] word_idx;
   logic [15:0] nxt_word;
   logic [1:0]  byte_idx;
   logic [1:0]  nxt_byte;
   logic [7:0]  run_xor;
   logic [7:0]  nxt_xor;
   logic [23:0] partial;
   logic [23:0] nxt_partial;
   logic [15:0] hi_count;
   logic        wr_fire;
   logic        xfer;

   assign xfer     = bus.rx_valid_i && bus.rx_ready_o;
   assign hi_count = {bus.rx_data_i, count[7:0]};

   always_comb begin
      nxt_state   = state;
      nxt_count   = count;
      nxt_word    = word_idx;
      nxt_byte    = byte_idx;
      nxt_xor     = run_xor;
      nxt_partial = partial;
      wr_fire     = 1'b0;
      case (state)
         S_CNT_LO: begin
            if (xfer) begin
               nxt_count = {8'h00, bus.rx_data_i};
               nxt_xor   = run_xor ^ bus.rx_data_i;
               nxt_state = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (xfer) begin
               nxt_count = hi_count;
               nxt_xor   = run_xor ^ bus.rx_data_i;
               if (hi_count > 16'(MEMORY_DEPTH)) begin
                  nxt_state = S_ERROR;
               end else if (hi_count == 16'd0) begin
                  nxt_state = S_CHECK;
               end else begin
                  nxt_state = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               nxt_xor = run_xor ^ bus.rx_data_i;
               case (byte_idx)
                  2'd0: begin nxt_partial[7:0]   = bus.rx_data_i; nxt_byte = 2'd1; end
                  2'd1: begin nxt_partial[15:8]  = bus.rx_data_i; nxt_byte = 2'd2; end
                  2'd2: begin nxt_partial[23:16] = bus.rx_data_i; nxt_byte = 2'd3; end
                  default: begin
                     // Last byte: the word leaves straight from the input, no extra buffering.
                     wr_fire  = 1'b1;
                     nxt_byte = 2'd0;
                     if (word_idx == count - 16'd1) begin
                        nxt_state = S_CHECK;
                     end else begin
                        nxt_word = word_idx + 16'd1;
                     end
                  end
               endcase
            end
         end
         S_CHECK: begin
            if (xfer) begin
               nxt_state = (bus.rx_data_i == run_xor) ? S_DONE : S_ERROR;
            end
         end
         default: nxt_state = state;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state           <= S_CNT_LO;
         count           <= '0;
         word_idx        <= '0;
         byte_idx        <= '0;
         run_xor         <= '0;
         partial         <= '0;
         bus.rx_ready_o  <= 1'b1;
         bus.wr_en_o     <= 1'b0;
         bus.wr_addr_o   <= '0;
         bus.wr_data_o   <= '0;
         bus.done_o      <= 1'b0;
         bus.error_o     <= 1'b0;
         bus.cpu_reset_o <= 1'b1;
      end else begin
         state    <= nxt_state;
         count    <= nxt_count;
         word_idx <= nxt_word;
         byte_idx <= nxt_byte;
         run_xor  <= nxt_xor;
         partial  <= nxt_partial;
         bus.wr_en_o <= wr_fire;
         if (wr_fire) begin
            bus.wr_addr_o <= BASE_ADDR + (DATA_WIDTH'(word_idx) << 2);
            bus.wr_data_o <= DATA_WIDTH'({bus.rx_data_i, partial});
         end
         // Status outputs follow the next state so they are registered yet not a cycle late.
         bus.rx_ready_o  <= (nxt_state != S_DONE) && (nxt_state != S_ERROR);
         bus.done_o      <= (nxt_state == S_DONE);
         bus.error_o     <= (nxt_state == S_ERROR);
         bus.cpu_reset_o <= (nxt_state != S_DONE);
      end
   end

endmodule
